ball_motion_fsm: RTL and testbench

//  Consumer of the 2-bit bounce event code (00 none, 01 paddle, 10 wall, 11 score) from the

---
 rtl/ball_motion_fsm.sv | 139 +++++++++++++
 tb/tb_ball_motion_fsm.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/ball_motion_fsm.sv
// Ball owner for the pong datapath: serve countdown, per-frame motion and bounce handling.
// Define BALL_SPEEDUP_EN to make each paddle hit raise the speed up to MAX_SPEED.
module ball_motion_fsm #(
    parameter int unsigned SCREEN_X     = 640,
    parameter int unsigned SCREEN_Y     = 480,
    parameter int unsigned BALL_SIZE    = 8,
    parameter int unsigned BALL_SPEED   = 2,
    parameter int unsigned SERVE_FRAMES = 60,
    parameter int unsigned MAX_SPEED    = 6
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       frame_tick,
    input  logic [1:0] bounce,
    output logic [9:0] ball_pos_x,
    output logic [9:0] ball_pos_y,
    output logic [7:0] ball_size_x,
    output logic [7:0] ball_size_y,
    output logic       ball_dir_x,
    output logic       ball_dir_y,
    output logic       serving,
    output logic [3:0] speed
);

    typedef enum logic [0:0] {StServe, StMove} state_t;

    localparam logic [10:0] X_MAX     = 11'(SCREEN_X - BALL_SIZE);
    localparam logic [10:0] Y_MAX     = 11'(SCREEN_Y - BALL_SIZE);
    localparam logic [9:0]  X_CENTRE  = 10'((SCREEN_X - BALL_SIZE) / 2);
    localparam logic [9:0]  Y_CENTRE  = 10'((SCREEN_Y - BALL_SIZE) / 2);
    localparam logic [3:0]  SPD_INIT  = 4'(BALL_SPEED);
    localparam logic [15:0] CNT_INIT  = 16'(SERVE_FRAMES);
`ifdef BALL_SPEEDUP_EN
    localparam logic [3:0]  SPEED_CAP = 4'(MAX_SPEED);
`else
    // Cap never above the serve speed, so speed cannot grow.
    localparam logic [3:0]  SPEED_CAP = 4'((MAX_SPEED < BALL_SPEED) ? MAX_SPEED : BALL_SPEED);
`endif

    state_t      state_q;
    logic [9:0]  pos_x_q, pos_y_q;
    logic        dir_x_q, dir_y_q;
    logic [3:0]  speed_q;
    logic [15:0] serve_cnt_q;
    logic [1:0]  prev_bounce_q;
    logic        serving_q;

    logic        evt, paddle, wall, score;
    logic        dir_x_nxt, dir_y_nxt;
    logic [3:0]  speed_nxt;

    // One saturating step along an axis; 11-bit math so neither edge can wrap.
    function automatic logic [9:0] step_axis(input logic [9:0] pos, input logic dir,
                                             input logic [3:0] spd, input logic [10:0] lim);
        logic [10:0] wide_pos;
        logic [10:0] wide_spd;
        logic [10:0] res;
        wide_pos = {1'b0, pos};
        wide_spd = {7'b0, spd};
        if (dir) begin
            res = wide_pos + wide_spd;
            if (res > lim) res = lim;
        end else if (wide_pos < wide_spd) begin
            res = 11'd0;
        end else begin
            res = wide_pos - wide_spd;
        end
        return res[9:0];
    endfunction

    // Edge-style event detect: a held code acts once, a direct code change acts again.
    always_comb begin
        evt       = (bounce != 2'b00) && (bounce != prev_bounce_q) && (state_q == StMove);
        paddle    = evt && (bounce == 2'b01);
        wall      = evt && (bounce == 2'b10);
        score     = evt && (bounce == 2'b11);
        dir_x_nxt = dir_x_q ^ paddle;
        dir_y_nxt = dir_y_q ^ wall;
        speed_nxt = (paddle && (speed_q < SPEED_CAP)) ? speed_q + 4'd1 : speed_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StServe;
            pos_x_q       <= X_CENTRE;
            pos_y_q       <= Y_CENTRE;
            dir_x_q       <= 1'b1;
            dir_y_q       <= 1'b1;
            speed_q       <= SPD_INIT;
            serve_cnt_q   <= CNT_INIT;
            prev_bounce_q <= 2'b00;
            serving_q     <= 1'b1;
        end else begin
            prev_bounce_q <= bounce;
            unique case (state_q)
                StServe: begin
                    if (frame_tick) begin
                        if ((CNT_INIT == 16'd0) || (serve_cnt_q == 16'd1)) begin
                            state_q   <= StMove;
                            serving_q <= 1'b0;
                        end
                        if (serve_cnt_q != 16'd0) serve_cnt_q <= serve_cnt_q - 16'd1;
                    end
                end
                StMove: begin
                    if (score) begin
                        // Re-serve toward the player who just scored.
                        state_q     <= StServe;
                        serving_q   <= 1'b1;
                        pos_x_q     <= X_CENTRE;
                        pos_y_q     <= Y_CENTRE;
                        dir_x_q     <= ~dir_x_q;
                        speed_q     <= SPD_INIT;
                        serve_cnt_q <= CNT_INIT;
                    end else begin
                        dir_x_q <= dir_x_nxt;
                        dir_y_q <= dir_y_nxt;
                        speed_q <= speed_nxt;
                        if (frame_tick) begin
                            pos_x_q <= step_axis(pos_x_q, dir_x_nxt, speed_q, X_MAX);
                            pos_y_q <= step_axis(pos_y_q, dir_y_nxt, speed_q, Y_MAX);
                        end
                    end
                end
                default: state_q <= StServe;
            endcase
        end
    end

    assign ball_pos_x  = pos_x_q;
    assign ball_pos_y  = pos_y_q;
    assign ball_size_x = 8'(BALL_SIZE);
    assign ball_size_y = 8'(BALL_SIZE);
    assign ball_dir_x  = dir_x_q;
    assign ball_dir_y  = dir_y_q;
    assign serving     = serving_q;
    assign speed       = speed_q;

endmodule

// File: tb/tb_ball_motion_fsm.sv
// Directed bench for ball_motion_fsm; position sequences assume the default build,
// the paddle speed-up steps follow BALL_SPEEDUP_EN.
module tb_ball_motion_fsm;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       frame_tick;
    logic [1:0] bounce;
    logic [9:0] ball_pos_x, ball_pos_y;
    logic [7:0] ball_size_x, ball_size_y;
    logic       ball_dir_x, ball_dir_y, serving;
    logic [3:0] speed;

    int vectors = 0;
    int miscompares = 0;

`ifdef BALL_SPEEDUP_EN
    int exp_spd[5] = '{3, 4, 5, 6, 6};
`else
    int exp_spd[5] = '{2, 2, 2, 2, 2};
`endif

    ball_motion_fsm dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .frame_tick (frame_tick),
        .bounce     (bounce),
        .ball_pos_x (ball_pos_x),
        .ball_pos_y (ball_pos_y),
        .ball_size_x(ball_size_x),
        .ball_size_y(ball_size_y),
        .ball_dir_x (ball_dir_x),
        .ball_dir_y (ball_dir_y),
        .serving    (serving),
        .speed      (speed)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one clock from a negedge; returns at the next negedge.
    task automatic step(input logic t, input logic [1:0] b);
        frame_tick = t;
        bounce     = b;
        @(negedge clock);
        frame_tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(1'b1, bounce);
    endtask

    task automatic chk_pos(input string tag, input int x, input int y);
        chk({tag, "_x"}, 32'(ball_pos_x), 32'(x));
        chk({tag, "_y"}, 32'(ball_pos_y), 32'(y));
    endtask

    initial begin
        reset_n    = 1'b1;
        frame_tick = 1'b0;
        bounce     = 2'b00;
        #2 reset_n = 1'b0;
        @(negedge clock);
        chk_pos("rst_pos", 316, 236);
        chk("rst_serving", 32'(serving), 1);
        chk("rst_dir_x", 32'(ball_dir_x), 1);
        chk("rst_dir_y", 32'(ball_dir_y), 1);
        chk("rst_speed", 32'(speed), 2);
        chk("size_x", 32'(ball_size_x), 8);
        chk("size_y", 32'(ball_size_y), 8);
        @(negedge clock);
        reset_n = 1'b1;

        // Serve countdown, then first move.
        ticks(59);
        chk("serve_59", 32'(serving), 1);
        chk_pos("serve_hold", 316, 236);
        ticks(1);
        chk("serve_60", 32'(serving), 0);
        ticks(1);
        chk_pos("first_move", 318, 238);

        // Paddle event in the same clock as a tick moves with the flipped direction.
        step(1'b1, 2'b01);
        chk("pad_tick_dir_x", 32'(ball_dir_x), 0);
        chk_pos("pad_tick", 316, 240);
        step(1'b0, 2'b00);

        // Wall code held across 8 clocks and 3 ticks flips only once.
        step(1'b1, 2'b10);
        step(1'b0, 2'b10);
        step(1'b1, 2'b10);
        step(1'b0, 2'b10);
        step(1'b1, 2'b10);
        step(1'b0, 2'b10);
        step(1'b0, 2'b10);
        step(1'b0, 2'b10);
        chk("wall_hold_dir_y", 32'(ball_dir_y), 0);
        chk_pos("wall_hold", 310, 234);
        step(1'b0, 2'b00);
        step(1'b0, 2'b10);
        chk("wall_again_dir_y", 32'(ball_dir_y), 1);
        step(1'b0, 2'b00);

        // Saturation at x=0 and y=472.
        ticks(155);
        chk_pos("clamp_lo_x", 0, 472);
        ticks(1);
        chk_pos("clamp_lo_x_hold", 0, 472);

        step(1'b0, 2'b01);
        step(1'b0, 2'b00);
        step(1'b0, 2'b10);
        step(1'b0, 2'b00);
        chk("turn_dir_x", 32'(ball_dir_x), 1);
        chk("turn_dir_y", 32'(ball_dir_y), 0);
        // Saturation at x=632 and y=0.
        ticks(316);
        chk_pos("clamp_hi_x", 632, 0);
        ticks(1);
        chk_pos("clamp_hi_x_hold", 632, 0);

        // Direct 01 -> 10 change fires both events.
        step(1'b0, 2'b01);
        step(1'b0, 2'b10);
        chk("direct_dir_x", 32'(ball_dir_x), 0);
        chk("direct_dir_y", 32'(ball_dir_y), 1);
        step(1'b0, 2'b00);

        // Score: recentre, serve toward scorer, events ignored while serving.
        step(1'b0, 2'b01);
        step(1'b0, 2'b00);
        chk("pre_score_dir_x", 32'(ball_dir_x), 1);
        step(1'b0, 2'b11);
        chk_pos("score_pos", 316, 236);
        chk("score_serving", 32'(serving), 1);
        chk("score_dir_x", 32'(ball_dir_x), 0);
        chk("score_dir_y", 32'(ball_dir_y), 1);
        step(1'b0, 2'b11);
        step(1'b0, 2'b00);
        step(1'b0, 2'b01);
        step(1'b0, 2'b00);
        step(1'b0, 2'b10);
        step(1'b0, 2'b00);
        chk("serve_ign_dir_x", 32'(ball_dir_x), 0);
        chk("serve_ign_dir_y", 32'(ball_dir_y), 1);
        ticks(3);
        chk_pos("serve_tick_pos", 316, 236);
        ticks(56);
        chk("reserve_59", 32'(serving), 1);
        ticks(1);
        chk("reserve_60", 32'(serving), 0);

        // Paddle events and speed.
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 2'b01);
            chk($sformatf("paddle_speed_%0d", i), 32'(speed), 32'(exp_spd[i]));
            step(1'b0, 2'b00);
        end
        chk("paddle5_dir_x", 32'(ball_dir_x), 1);
        step(1'b0, 2'b11);
        chk("score_speed", 32'(speed), 2);
        chk("score2_dir_x", 32'(ball_dir_x), 0);
        step(1'b0, 2'b00);

        // Asynchronous reset in mid-move.
        ticks(60);
        ticks(2);
        chk_pos("pre_reset", 312, 240);
        #2 reset_n = 1'b0;
        #1;
        chk_pos("async_rst", 316, 236);
        chk("async_rst_serving", 32'(serving), 1);
        chk("async_rst_dir_x", 32'(ball_dir_x), 1);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        ticks(60);
        chk("post_rst_serving", 32'(serving), 0);
        ticks(1);
        chk_pos("post_rst_move", 318, 238);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
